// File: rtl/lab1_vector_checker.sv
// Sweeps ABCD through 0..15, holds each vector HOLD_CYCLES cycles and checks F against EXPECTED.
// Optional feature macro: LAB1_FIRST_FAIL_EN records the index of the first failing vector.
module lab1_vector_checker #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXPECTED    = 16'hA5C3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       f_in,
  output logic [3:0] abcd_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       mismatch,
  output logic [3:0] first_fail_idx,
  output logic       first_fail_vld
);

  // state | meaning
  // IDLE  | waiting for start, abcd_out parked at 0
  // DRIVE | sweeping vectors, busy high
  // DONE  | one-cycle completion, done high
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] hold_cnt;
  logic [3:0] vec;
  logic       start_acc;
  logic       sample;
  logic       last_sample;
  logic       f_bad;

  always_comb begin
    start_acc   = (state == IDLE) && start;
    sample      = (state == DRIVE) && (hold_cnt == 8'd0);
    last_sample = sample && (vec == 4'hF);
    f_bad       = sample && (f_in != EXPECTED[vec]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = DRIVE;
      end
      DRIVE: begin
        busy = 1'b1;
        if (last_sample) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold timer counts down from HOLD_CYCLES-1; terminal count is the sample edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= 8'd0;
      vec       <= 4'd0;
      err_count <= 5'd0;
      pass      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      mismatch <= f_bad;
      if (start_acc) begin
        hold_cnt  <= HOLD_LOAD;
        vec       <= 4'd0;
        err_count <= 5'd0;
        pass      <= 1'b0;
      end else if (sample) begin
        hold_cnt <= HOLD_LOAD;
        vec      <= last_sample ? 4'd0 : vec + 4'd1;
        if (f_bad) err_count <= err_count + 5'd1;
        if (last_sample) pass <= (err_count == 5'd0) && !f_bad;
      end else if (state == DRIVE) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

  assign abcd_out = vec;

`ifdef LAB1_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_idx <= 4'd0;
      first_fail_vld <= 1'b0;
    end else if (start_acc) begin
      first_fail_idx <= 4'd0;
      first_fail_vld <= 1'b0;
    end else if (f_bad && !first_fail_vld) begin
      first_fail_idx <= vec;
      first_fail_vld <= 1'b1;
    end
  end
`else
  assign first_fail_idx = 4'd0;
  assign first_fail_vld = 1'b0;
`endif

endmodule

// File: tb/tb_lab1_vector_checker.sv
// Directed bench for lab1_vector_checker: table of sweep scenarios plus reset-abort,
// start re-pulse and HOLD_CYCLES=1 sequences.
module tb_lab1_vector_checker;

  localparam logic [15:0] GOLD = 16'hA5C3;
`ifdef LAB1_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start, start1;
  logic       f_in, f_in1;
  logic [3:0] abcd_out, abcd1;
  logic       busy, done, pass, mismatch;
  logic       busy1, done1, pass1, mis1;
  logic [4:0] err_count, err1;
  logic [3:0] first_fail_idx, ffi1;
  logic       first_fail_vld, ffv1;

  int mode;
  int tests;
  int fails;

  // mode 0: golden, 1: golden inverted at vector 5, 2: stuck at 0
  assign f_in  = (mode == 2) ? 1'b0 : (GOLD[abcd_out] ^ ((mode == 1) && (abcd_out == 4'd5)));
  assign f_in1 = GOLD[abcd1];

  lab1_vector_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .abcd_out(abcd_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .mismatch(mismatch),
    .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  lab1_vector_checker #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f_in1),
    .abcd_out(abcd1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .mismatch(mis1),
    .first_fail_idx(ffi1), .first_fail_vld(ffv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulses start, then counts negedges until done; k=0 is the negedge right after acceptance.
  task automatic sweep(input int m, input bit repulse,
                       output int done_cyc, output int mis_n, output int seq_bad);
    mode     = m;
    done_cyc = -1;
    mis_n    = 0;
    seq_bad  = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      start = repulse && (k == 10);
      if (mismatch) mis_n++;
      if (done) begin
        done_cyc = k;
        break;
      end
      if (!busy || abcd_out != 4'(k / 4)) seq_bad++;
    end
    start = 1'b0;
  endtask

  typedef struct {
    string      name;
    int         mode;
    int         exp_err;
    bit         exp_pass;
    logic [3:0] exp_ffi;
    bit         exp_ffv;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int dc, mn, sb, stray;

    tbl[0] = '{"golden",  0, 0, 1'b1, 4'd0,               1'b0};
    tbl[1] = '{"inv5",    1, 1, 1'b0, FF_EN ? 4'd5 : 4'd0, FF_EN};
    tbl[2] = '{"stuck0",  2, 8, 1'b0, 4'd0,               FF_EN};

    tests = 0; fails = 0; mode = 0;
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_abcd", abcd_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_ffv", first_fail_vld, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      sweep(tbl[i].mode, 1'b0, dc, mn, sb);
      check({tbl[i].name, "_done_cyc"}, dc, 64);
      check({tbl[i].name, "_mis_pulses"}, mn, tbl[i].exp_err);
      check({tbl[i].name, "_seq"}, sb, 0);
      check({tbl[i].name, "_busy_in_done"}, busy, 0);
      check({tbl[i].name, "_err"}, err_count, tbl[i].exp_err);
      check({tbl[i].name, "_pass"}, pass, tbl[i].exp_pass);
      check({tbl[i].name, "_ffi"}, first_fail_idx, tbl[i].exp_ffi);
      check({tbl[i].name, "_ffv"}, first_fail_vld, tbl[i].exp_ffv);
      @(negedge clk);
      check({tbl[i].name, "_done_1cyc"}, done, 0);
      check({tbl[i].name, "_idle_abcd"}, abcd_out, 0);
      check({tbl[i].name, "_err_held"}, err_count, tbl[i].exp_err);
      check({tbl[i].name, "_pass_held"}, pass, tbl[i].exp_pass);
      check({tbl[i].name, "_ffi_held"}, first_fail_idx, tbl[i].exp_ffi);
    end

    // start re-pulsed mid-sweep and while in DONE must be ignored
    sweep(0, 1'b1, dc, mn, sb);
    check("repulse_done_cyc", dc, 64);
    check("repulse_seq", sb, 0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      if (busy || done) stray++;
      @(negedge clk);
    end
    check("repulse_no_restart", stray, 0);
    check("repulse_pass", pass, 1);
    check("repulse_err", err_count, 0);

    // reset at cycle 20 aborts the sweep
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_err", err_count, 2);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_abcd", abcd_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err_count, 0);
    check("abort_mis", mismatch, 0);
    check("abort_pass", pass, 0);
    check("abort_ffv", first_fail_vld, 0);
    check("abort_ffi", first_fail_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("abort_no_done", stray, 0);
    sweep(0, 1'b0, dc, mn, sb);
    check("post_rst_done_cyc", dc, 64);
    check("post_rst_seq", sb, 0);
    check("post_rst_pass", pass, 1);
    check("post_rst_err", err_count, 0);
    check("post_rst_mis", mn, 0);

    // HOLD_CYCLES=1: new vector every cycle, done at cycle 16
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    stray = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("h1_abcd_%0d", k), abcd1, k);
      if (!busy1 || done1 || mis1) stray++;
    end
    check("h1_busy_seq", stray, 0);
    @(negedge clk);
    check("h1_done", done1, 1);
    check("h1_pass", pass1, 1);
    check("h1_err", err1, 0);
    check("h1_ffv", ffv1, 0);
    check("h1_ffi", ffi1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
